// File: rtl/sum_stream_rx_if.sv
// Stream-side signals of sum_stream_rx: beat input handshake and frame-total output handshake.
// out_max exists only when SUM_STREAM_MAX_EN is defined.
interface sum_stream_rx_if #(
   parameter int LANES = 6,
   parameter int W     = 5,
   parameter int SW    = 11
);
   logic                 in_valid;
   logic                 in_ready;
   logic [LANES*W-1:0]   in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [SW-1:0]        out_sum;
`ifdef SUM_STREAM_MAX_EN
   logic [W-1:0]         out_max;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum, out_max
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum, out_max
   );
`else
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum
   );
`endif
endinterface

// File: rtl/sum_stream_rx.sv
// Frame summer for a stream of LANES-wide beats: per-lane accumulation, pairwise reduction, one total per frame.
// Optional running maximum of the frame elements on out_max when SUM_STREAM_MAX_EN is defined.
module sum_stream_rx #(
   parameter int N     = 40,
   parameter int LANES = 6,
   parameter int W     = 5,
   localparam int SW   = W + $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   sum_stream_rx_if.slave   bus
);
   localparam int BEATS      = (N + LANES - 1) / LANES;
   localparam int LAST_LANES = N - (BEATS - 1) * LANES;
   localparam int R          = $clog2(LANES);
   localparam int HALF       = (LANES + 1) / 2;
   localparam int BCW        = $clog2(BEATS + 1);
   localparam int RCW        = $clog2(R + 1);

   typedef enum logic [1:0] {ACCUM, REDUCE, DONE} state_t;

   state_t            state_q, state_d;
   logic [BCW-1:0]    beat_q, beat_d;
   logic [RCW-1:0]    red_q, red_d;
   logic [SW-1:0]     partial_q [LANES];
   logic [SW-1:0]     partial_d [LANES];
   logic [SW-1:0]     ext       [LANES+1];
   logic              accept;
   logic              lastBeat;
`ifdef SUM_STREAM_MAX_EN
   logic [W-1:0]      max_q, max_d;
`endif

   // Partials above the active count are always zero, so a zero pad makes odd pass-through an ordinary add.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         ext[i] = partial_q[i];
      end
      ext[LANES] = '0;
   end

   always_comb begin
      accept    = (state_q == ACCUM) && bus.in_valid;
      lastBeat  = (beat_q == BCW'(BEATS - 1));
      state_d   = state_q;
      beat_d    = beat_q;
      red_d     = red_q;
      partial_d = partial_q;
`ifdef SUM_STREAM_MAX_EN
      max_d     = max_q;
`endif
      case (state_q)
         ACCUM: begin
            if (accept) begin
               for (int k = 0; k < LANES; k++) begin
                  if (!lastBeat || (k < LAST_LANES)) begin
                     partial_d[k] = partial_q[k] + SW'(bus.in_data[k*W +: W]);
`ifdef SUM_STREAM_MAX_EN
                     if (bus.in_data[k*W +: W] > max_d) begin
                        max_d = bus.in_data[k*W +: W];
                     end
`endif
                  end
               end
               if (lastBeat) begin
                  state_d = REDUCE;
                  beat_d  = '0;
                  red_d   = '0;
               end else begin
                  beat_d  = beat_q + 1'b1;
               end
            end
         end
         REDUCE: begin
            for (int i = 0; i < HALF; i++) begin
               partial_d[i] = ext[2*i] + ext[2*i+1];
            end
            for (int i = HALF; i < LANES; i++) begin
               partial_d[i] = '0;
            end
            red_d = red_q + 1'b1;
            if (red_q == RCW'(R - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               for (int i = 0; i < LANES; i++) begin
                  partial_d[i] = '0;
               end
`ifdef SUM_STREAM_MAX_EN
               max_d   = '0;
`endif
               state_d = ACCUM;
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ACCUM;
         beat_q  <= '0;
         red_q   <= '0;
         for (int i = 0; i < LANES; i++) begin
            partial_q[i] <= '0;
         end
`ifdef SUM_STREAM_MAX_EN
         max_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         red_q     <= red_d;
         partial_q <= partial_d;
`ifdef SUM_STREAM_MAX_EN
         max_q     <= max_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == ACCUM);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_sum   = partial_q[0];
`ifdef SUM_STREAM_MAX_EN
   assign bus.out_max   = max_q;
`endif

endmodule

// File: tb/tb_sum_stream_rx.sv
// Scoreboard bench for sum_stream_rx; expected totals are queued as frames are driven and popped on output handshakes.
// Also checks out_max when SUM_STREAM_MAX_EN is defined.
module tb_sum_stream_rx;
   localparam int N     = 40;
   localparam int LANES = 6;
   localparam int W     = 5;
   localparam int SW    = W + $clog2(N);
   localparam int BEATS = (N + LANES - 1) / LANES;
   localparam int R     = $clog2(LANES);

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   sum_stream_rx_if #(.LANES(LANES), .W(W), .SW(SW)) bus ();

   sum_stream_rx #(.N(N), .LANES(LANES), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   int            lastAcceptEdge = 0;
   int            hsEdge = 0;
   int            lowReady = 0;
   int            riseEdges [$];
   logic          prevValid = 1'b0;
   logic [SW-1:0] expSum [$];
   logic [W-1:0]  expMax [$];
   logic [W-1:0]  frame [N];

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: handshake seen at a negedge completes on the following posedge.
   always @(negedge clk) begin
      logic [SW-1:0] s;
      logic [W-1:0]  m;
      if (rst === 1'b0) begin
         if (bus.in_ready === 1'b0) lowReady++;
         if (bus.out_valid === 1'b1 && prevValid !== 1'b1) riseEdges.push_back(cyc);
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            hsEdge = cyc + 1;
            total++;
            if (expSum.size() == 0) begin
               bad++;
               $display("[TB] FAIL unexpected_output got sum=%0d want no output", bus.out_sum);
            end else begin
               s = expSum.pop_front();
               m = expMax.pop_front();
               if (bus.out_sum !== s) begin
                  bad++;
                  $display("[TB] FAIL frame_sum got %0d want %0d", bus.out_sum, s);
               end
`ifdef SUM_STREAM_MAX_EN
               total++;
               if (bus.out_max !== m) begin
                  bad++;
                  $display("[TB] FAIL frame_max got %0d want %0d", bus.out_max, m);
               end
`endif
            end
         end
      end
      prevValid = bus.out_valid;
   end

   task automatic fill_frame(input logic [W-1:0] v);
      for (int i = 0; i < N; i++) frame[i] = v;
   endtask

   task automatic drive_frame(input int nbeats, input int gapPct, input logic [W-1:0] garbage);
      logic [LANES*W-1:0] d;
      logic [SW-1:0]      s;
      logic [W-1:0]       m;
      logic               accepted;
      int                 idx;
      int                 t;
      if (nbeats == BEATS) begin
         s = '0;
         m = '0;
         for (int i = 0; i < N; i++) begin
            s = s + SW'(frame[i]);
            if (frame[i] > m) m = frame[i];
         end
         expSum.push_back(s);
         expMax.push_back(m);
      end
      for (int b = 0; b < nbeats; b++) begin
         while (int'($urandom_range(99)) < gapPct) begin
            bus.in_valid = 1'b0;
            bus.in_data  = (LANES*W)'({$urandom(), $urandom()});
            @(posedge clk); #1;
         end
         for (int k = 0; k < LANES; k++) begin
            idx = b * LANES + k;
            if (idx < N) d[k*W +: W] = frame[idx];
            else         d[k*W +: W] = garbage;
         end
         bus.in_valid = 1'b1;
         bus.in_data  = d;
         accepted = 1'b0;
         t = 0;
         while (!accepted && t < 50) begin
            accepted = (bus.in_ready === 1'b1);
            if (accepted) lastAcceptEdge = cyc + 1;
            @(posedge clk); #1;
            t++;
         end
         if (!accepted) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout beat=%0d got in_ready=%b want 1", b, bus.in_ready);
         end
      end
   endtask

   task automatic wait_drain();
      int t = 0;
      while (expSum.size() != 0 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      total++;
      if (expSum.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain_timeout got pending=%0d want 0", expSum.size());
         expSum.delete();
         expMax.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      total += 3;
      if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got %b want 1", bus.in_ready); end
      if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); end
      if (bus.out_sum !== '0) begin bad++; $display("[TB] FAIL reset_out_sum got %0d want 0", bus.out_sum); end
`ifdef SUM_STREAM_MAX_EN
      total++;
      if (bus.out_max !== '0) begin bad++; $display("[TB] FAIL reset_out_max got %0d want 0", bus.out_max); end
`endif
      rst = 1'b0;
   endtask

   task automatic test_all_ones();
      fill_frame(W'(1));
      bus.out_ready = 1'b1;
      lowReady = 0;
      drive_frame(BEATS, 0, W'(1));
      bus.in_valid = 1'b0;
      wait_drain();
      total += 2;
      if (hsEdge - lastAcceptEdge != R + 1) begin
         bad++;
         $display("[TB] FAIL latency got %0d want %0d", hsEdge - lastAcceptEdge, R + 1);
      end
      if (lowReady != R + 1) begin
         bad++;
         $display("[TB] FAIL ready_low_cycles got %0d want %0d", lowReady, R + 1);
      end
   endtask

   task automatic test_max_value();
      fill_frame(W'(31));
      bus.out_ready = 1'b1;
      drive_frame(BEATS, 0, W'(31));
      bus.in_valid = 1'b0;
      wait_drain();
   endtask

   task automatic test_ramp_gaps();
      for (int i = 0; i < N; i++) frame[i] = W'(i + 1);
      bus.out_ready = 1'b1;
      drive_frame(BEATS, 30, W'(31));
      bus.in_valid = 1'b0;
      wait_drain();
   endtask

   task automatic test_hold();
      int t = 0;
      fill_frame(W'(4));
      bus.out_ready = 1'b0;
      drive_frame(BEATS, 0, W'(9));
      bus.in_valid = 1'b0;
      while (bus.out_valid !== 1'b1 && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      for (int c = 0; c < 5; c++) begin
         total += 3;
         if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL hold_valid cyc=%0d got %b want 1", c, bus.out_valid); end
         if (bus.out_sum !== SW'(160)) begin bad++; $display("[TB] FAIL hold_sum cyc=%0d got %0d want 160", c, bus.out_sum); end
         if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL hold_in_ready cyc=%0d got %b want 0", c, bus.in_ready); end
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      total += 2;
      if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_in_ready got %b want 1", bus.in_ready); end
      if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL release_out_valid got %b want 0", bus.out_valid); end
      wait_drain();
   endtask

   task automatic test_reset_mid();
      fill_frame(W'(7));
      bus.out_ready = 1'b1;
      drive_frame(3, 0, W'(7));
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total += 3;
      if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL midrst_in_ready got %b want 1", bus.in_ready); end
      if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_out_valid got %b want 0", bus.out_valid); end
      if (bus.out_sum !== '0) begin bad++; $display("[TB] FAIL midrst_out_sum got %0d want 0", bus.out_sum); end
      fill_frame(W'(2));
      drive_frame(BEATS, 0, W'(7));
      bus.in_valid = 1'b0;
      wait_drain();
   endtask

   task automatic test_back_to_back();
      riseEdges.delete();
      bus.out_ready = 1'b1;
      fill_frame(W'(3));
      drive_frame(BEATS, 0, W'(3));
      fill_frame(W'(5));
      drive_frame(BEATS, 0, W'(5));
      bus.in_valid = 1'b0;
      wait_drain();
      total++;
      if (riseEdges.size() != 2) begin
         bad++;
         $display("[TB] FAIL b2b_rises got %0d want 2", riseEdges.size());
      end else begin
         total++;
         if (riseEdges[1] - riseEdges[0] != BEATS + R + 1) begin
            bad++;
            $display("[TB] FAIL b2b_period got %0d want %0d", riseEdges[1] - riseEdges[0], BEATS + R + 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_all_ones();
      test_max_value();
      test_ramp_gaps();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got no finish want finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
